// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS32 subset core sharing one ALU and one stallable
// unified instruction/data memory port (req/ready handshake).
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_WIDTH  = 32,
    parameter bit          HALT_ON_ILL = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic                  instr_retired_o,
    output logic                  halted_o,
    output logic [31:0]           pc_out_o
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEMADR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic        go_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, rf_wa;
    logic [31:0] simm, alu_a, alu_b, alu_y, addr, rf_wd;
    logic        is_r, is_mem, is_br, is_addi, is_j, illegal, misalign, xfer, rf_we;

    assign op   = ir_q[31:26];
    assign rs   = ir_q[25:21];
    assign rt   = ir_q[20:16];
    assign rd   = ir_q[15:11];
    assign fn   = ir_q[5:0];
    assign simm = {{16{ir_q[15]}}, ir_q[15:0]};

    assign is_r    = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
    assign is_mem  = op == 6'h23 || op == 6'h2B;
    assign is_br   = op == 6'h04 || op == 6'h05;
    assign is_addi = op == 6'h08;
    assign is_j    = op == 6'h02 || op == 6'h03;
    assign illegal = !(is_r || is_mem || is_br || is_addi || is_j);

    // The one ALU: branch target in DECODE, R-type op in EXEC_R, base+offset otherwise.
    always_comb begin
        alu_a    = state_q == S_DECODE ? pc_q : a_q;
        alu_b    = state_q == S_DECODE ? {simm[29:0], 2'b00} : state_q == S_EXEC_R ? b_q : simm;
        alu_y    = state_q != S_EXEC_R ? alu_a + alu_b
                 : fn == 6'h22 ? alu_a - alu_b
                 : fn == 6'h24 ? alu_a & alu_b
                 : fn == 6'h25 ? alu_a | alu_b
                 : fn == 6'h2A ? {31'd0, $signed(alu_a) < $signed(alu_b)}
                 : alu_a + alu_b;
        misalign = alu_y[1:0] != 2'b00;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = xfer ? S_DECODE : S_FETCH;
            S_DECODE: state_d = illegal ? (HALT_ON_ILL ? S_HALT : S_FETCH)
                              : is_r ? S_EXEC_R : is_mem ? S_MEMADR
                              : is_addi ? S_EXEC_I : is_br ? S_BRANCH : S_JUMP;
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_MEMADR: state_d = misalign ? (HALT_ON_ILL ? S_HALT : S_FETCH) : op[3] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = xfer ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: state_d = xfer ? S_FETCH : S_MEM_WR;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // go_q keeps the port idle until the first edge after reset release.
    always_comb begin
        mem_req_o       = go_q && (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR);
        mem_we_o        = mem_req_o && state_q == S_MEM_WR;
        addr            = state_q == S_FETCH ? pc_q : alu_q;
        mem_addr_o      = mem_req_o ? addr[ADDR_WIDTH-1:0] : '0;
        mem_wdata_o     = mem_we_o ? b_q : '0;
        xfer            = mem_req_o && mem_ready_i;
        instr_retired_o = state_q == S_WB_R || state_q == S_WB_I || state_q == S_WB_MEM
                       || state_q == S_BRANCH || state_q == S_JUMP || (state_q == S_MEM_WR && xfer)
                       || (!HALT_ON_ILL && ((state_q == S_DECODE && illegal) || (state_q == S_MEMADR && misalign)));
        halted_o        = state_q == S_HALT;
        pc_out_o        = state_q == S_FETCH ? pc_q : pc_q - 32'd4;
        rf_we           = state_q == S_WB_R || state_q == S_WB_I || state_q == S_WB_MEM
                       || (state_q == S_JUMP && op == 6'h03);
        rf_wa           = state_q == S_WB_R ? rd : state_q == S_JUMP ? 5'd31 : rt;
        rf_wd           = state_q == S_WB_MEM ? mdr_q : state_q == S_JUMP ? pc_q : alu_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            go_q  <= 1'b0;
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            go_q <= 1'b1;
            if (state_q == S_FETCH && xfer) begin
                ir_q <= mem_rdata_i;
                pc_q <= pc_q + 32'd4;
            end
            if (state_q == S_DECODE) begin
                a_q <= rf_q[rs];
                b_q <= rf_q[rt];
            end
            if (state_q inside {S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR}) alu_q <= alu_y;
            if (state_q == S_MEM_RD && xfer) mdr_q <= mem_rdata_i;
            if (state_q == S_BRANCH && ((a_q == b_q) ^ op[0])) pc_q <= alu_q;
            if (state_q == S_JUMP) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: table-driven program run against a behavioural memory with
// programmable wait states; registers are observed through store data.
module tb_mips_multicycle_core;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retired, halted;
    logic [31:0] addr, wdata, rdata, pc_out;
    logic [31:0] mem [256];
    bit          ready_en = 1'b0;
    int          wait_n = 0, stall_q = 0, cyc = 0, checks = 0, failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          lat;
        bit          st;
        logic [31:0] sd;
    } vec_t;
    vec_t vec [30];

    always #5 clk = ~clk;

    assign mem_ready = ready_en && stall_q >= wait_n;
    assign rdata     = mem[addr[9:2]];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        stall_q <= (mem_req && !mem_ready) ? stall_q + 1 : 0;
    end

    always @(posedge clk) if (mem_req && mem_we && mem_ready) mem[addr[9:2]] = wdata;

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_WIDTH(32), .HALT_ON_ILL(1'b1)) dut (
        .clk_i(clk), .reset_i(rst), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(addr),
        .mem_wdata_o(wdata), .mem_rdata_i(rdata), .mem_ready_i(mem_ready),
        .instr_retired_o(retired), .halted_o(halted), .pc_out_o(pc_out)
    );

    function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] ri(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] jj(input int op, input int t);
        return {6'(op), 26'(t)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Fetch address, latency from fetch issue to retire, debug PC, stall stability, store data.
    task automatic run_vec(input int i);
        int n, t0;
        bit pend, stable, st_seen;
        logic [31:0] a0, w0, sd;
        @(negedge clk);
        n = 0;
        while (!(mem_req && !mem_we) && n < 100) begin @(negedge clk); n++; end
        chk($sformatf("fetch_addr[%0d]", i), addr, vec[i].pc);
        t0 = cyc; stable = 1'b1; st_seen = 1'b0; sd = 32'hDEAD_BEEF;
        pend = mem_req && !mem_ready; a0 = addr; w0 = wdata;
        n = 0;
        while (!retired && n < 100) begin
            @(negedge clk); n++;
            if (pend && !(mem_req && addr == a0 && wdata == w0)) stable = 1'b0;
            if (mem_req && mem_we && mem_ready) begin st_seen = 1'b1; sd = wdata; end
            pend = mem_req && !mem_ready; a0 = addr; w0 = wdata;
        end
        chk($sformatf("latency[%0d]", i), 32'(cyc - t0 + 1), 32'(vec[i].lat));
        chk($sformatf("pc_out[%0d]", i), pc_out, vec[i].pc);
        if (wait_n > 0) chk($sformatf("stall_stable[%0d]", i), 32'(stable), 32'd1);
        if (vec[i].st) chk($sformatf("store_data[%0d]", i), st_seen ? sd : 32'hDEAD_BEEF, vec[i].sd);
    endtask

    task automatic halt_seq(input string nm, input logic [31:0] pc, input int k);
        int n;
        bit bad;
        @(negedge clk);
        n = 0;
        while (!(mem_req && !mem_we) && n < 100) begin @(negedge clk); n++; end
        chk({nm, "_fetch"}, addr, pc);
        bad = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (retired || (j > wait_n && mem_req)) bad = 1'b1;
            if (j == k - 1) chk({nm, "_not_yet"}, 32'(halted), 32'd0);
            if (j == k) chk({nm, "_halted"}, 32'(halted), 32'd1);
        end
        chk({nm, "_quiet"}, 32'(bad), 32'd0);
        chk({nm, "_pc_out"}, pc_out, pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{32'h000, ri(8, 0, 1, 5), 4, 1'b0, 32'h0};
        vec[1]  = '{32'h004, ri(8, 0, 2, -3), 4, 1'b0, 32'h0};
        vec[2]  = '{32'h008, rr(1, 2, 3, 'h20), 4, 1'b0, 32'h0};
        vec[3]  = '{32'h00C, rr(2, 1, 4, 'h2A), 4, 1'b0, 32'h0};
        vec[4]  = '{32'h010, ri(4, 1, 1, 2), 3, 1'b0, 32'h0};
        vec[5]  = '{32'h01C, ri(5, 1, 1, 2), 3, 1'b0, 32'h0};
        vec[6]  = '{32'h020, jj(3, 'h40), 3, 1'b0, 32'h0};
        vec[7]  = '{32'h100, ri(8, 0, 0, 7), 4, 1'b0, 32'h0};
        vec[8]  = '{32'h104, ri('h2B, 0, 3, 'h200), 4, 1'b1, 32'd2};
        vec[9]  = '{32'h108, ri('h2B, 0, 4, 'h204), 4, 1'b1, 32'd1};
        vec[10] = '{32'h10C, ri('h2B, 0, 31, 'h208), 4, 1'b1, 32'h24};
        vec[11] = '{32'h110, ri('h2B, 0, 0, 'h20C), 4, 1'b1, 32'd0};
        vec[12] = '{32'h114, ri('h23, 0, 5, 'h200), 5, 1'b0, 32'h0};
        vec[13] = '{32'h118, ri('h2B, 0, 5, 'h210), 4, 1'b1, 32'd2};
        vec[14] = '{32'h11C, rr(1, 2, 6, 'h22), 4, 1'b0, 32'h0};
        vec[15] = '{32'h120, rr(1, 2, 7, 'h24), 4, 1'b0, 32'h0};
        vec[16] = '{32'h124, rr(1, 2, 8, 'h25), 4, 1'b0, 32'h0};
        vec[17] = '{32'h128, rr(1, 2, 9, 'h2A), 4, 1'b0, 32'h0};
        vec[18] = '{32'h12C, ri(5, 1, 2, 1), 3, 1'b0, 32'h0};
        vec[19] = '{32'h134, ri('h2B, 0, 6, 'h214), 4, 1'b1, 32'd8};
        vec[20] = '{32'h138, ri('h2B, 0, 7, 'h218), 4, 1'b1, 32'd5};
        vec[21] = '{32'h13C, ri('h2B, 0, 8, 'h21C), 4, 1'b1, 32'hFFFF_FFFD};
        vec[22] = '{32'h140, ri('h2B, 0, 9, 'h220), 4, 1'b1, 32'd0};
        vec[23] = '{32'h144, jj(2, 'h60), 3, 1'b0, 32'h0};
        vec[24] = '{32'h180, ri('h2B, 0, 1, 'h224), 4, 1'b1, 32'd5};
        vec[25] = '{32'h000, ri(8, 0, 3, 2), 7, 1'b0, 32'h0};
        vec[26] = '{32'h004, ri('h2B, 0, 3, 'h200), 10, 1'b1, 32'd2};
        vec[27] = '{32'h008, ri('h23, 0, 5, 'h200), 11, 1'b0, 32'h0};
        vec[28] = '{32'h00C, ri('h2B, 0, 5, 'h204), 10, 1'b1, 32'd2};
        vec[29] = '{32'h010, ri('h2B, 0, 7, 'h208), 10, 1'b1, 32'd0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 25; i++) mem[vec[i].pc[9:2]] = vec[i].ins;
        mem[32'h184 >> 2] = 32'hFC00_0000;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_fetch_req", 32'(mem_req), 32'd1);
        chk("first_fetch_addr", addr, 32'h0);
        repeat (2) @(negedge clk);
        chk("fetch_held", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("mid_fetch_req_drop", 32'(mem_req), 32'd0);
        chk("mid_fetch_addr_zero", addr, 32'h0);
        @(negedge clk);
        rst = 1'b0; ready_en = 1'b1; wait_n = 0;
        for (int i = 0; i < 25; i++) run_vec(i);
        halt_seq("illegal", 32'h184, 2);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 25; i < 30; i++) mem[vec[i].pc[9:2]] = vec[i].ins;
        mem[32'h14 >> 2] = ri('h23, 0, 6, 6);
        wait_n = 3;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 25; i < 30; i++) run_vec(i);
        halt_seq("misalign", 32'h14, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
